// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one memory bus among NUM_MASTERS masters.
// Define ARB_TIMEOUT_EN to compile in the watchdog that faults stalled slaves.
module mem_arbiter_rr #(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [32*NUM_MASTERS-1:0]        m_address_in,
  input  logic [NUM_MASTERS-1:0]           m_read_in,
  input  logic [NUM_MASTERS-1:0]           m_write_in,
  input  logic [4*NUM_MASTERS-1:0]         m_write_mask_in,
  input  logic [32*NUM_MASTERS-1:0]        m_write_value_in,
  output logic [32*NUM_MASTERS-1:0]        m_read_value_out,
  output logic [NUM_MASTERS-1:0]           m_ready_out,
  output logic [NUM_MASTERS-1:0]           m_fault_out,
  output logic [31:0]                      address_out,
  output logic                             read_out,
  output logic                             write_out,
  output logic [3:0]                       write_mask_out,
  output logic [31:0]                      write_value_out,
  input  logic [31:0]                      read_value_in,
  input  logic                             ready_in,
  input  logic                             fault_in,
  output logic [$clog2(NUM_MASTERS)-1:0]   grant_out,
  output logic                             busy_out
);
  localparam int GW = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           pick;
  logic [NUM_MASTERS-1:0]  req;
  logic [31:0]             addr_arr  [NUM_MASTERS];
  logic [31:0]             wdata_arr [NUM_MASTERS];
  logic [3:0]              mask_arr  [NUM_MASTERS];
  logic                    busy;
  logic                    timeout_hit;
  logic                    done;

  assign busy = (state == BUSY);
  // Completion is suppressed while reset is held so an abandoned transfer never signals ready.
  assign done = busy && reset && (ready_in || timeout_hit);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      logic sel;
      assign sel                = (grant == GW'(gi));
      assign addr_arr[gi]       = m_address_in[32*gi +: 32];
      assign wdata_arr[gi]      = m_write_value_in[32*gi +: 32];
      assign mask_arr[gi]       = m_write_mask_in[4*gi +: 4];
      assign req[gi]            = m_read_in[gi] | m_write_in[gi];
      assign m_ready_out[gi]    = done && sel;
      assign m_fault_out[gi]    = done && sel && (ready_in ? fault_in : 1'b1);
      assign m_read_value_out[32*gi +: 32] =
        (done && sel && ready_in) ? read_value_in : 32'd0;
    end
  endgenerate

  // First requester after last_grant, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = last_grant;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(last_grant) + k) % NUM_MASTERS;
      if (!found && req[GW'(idx)]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  assign address_out     = busy ? addr_arr[grant]  : 32'd0;
  assign write_value_out = busy ? wdata_arr[grant] : 32'd0;
  assign write_mask_out  = busy ? mask_arr[grant]  : 4'd0;
  assign read_out        = busy && m_read_in[grant]  && !timeout_hit;
  assign write_out       = busy && m_write_in[grant] && !timeout_hit;
  assign grant_out       = grant;
  assign busy_out        = busy;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wd_count;

  assign timeout_hit = busy && !ready_in && (wd_count == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_count <= 16'd0;
    end else if (!busy) begin
      wd_count <= 16'd0;
    end else if (!ready_in) begin
      wd_count <= wd_count + 16'd1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (ready_in || timeout_hit) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
